// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Tracking entries carry a fixed-width rd so one struct serves any REG_ADDR_W up to TRK_RD_W.
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int TRK_RD_W       = 8;

  typedef struct packed {
    logic                valid;
    logic [TRK_RD_W-1:0] rd;
    logic                is_load;
  } trk_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request bundle and hazard/forwarding responses of pipe_hazard_ctrl.
// Purely combinational handshake: no backpressure beyond the stall/flush outputs themselves.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_we;
  logic                  id_is_load;
  logic                  ex_jump_taken;
  logic                  stall;
  logic                  flush;
  logic                  issue;
  logic [SEL_W-1:0]      fwd_sel_a;
  logic [SEL_W-1:0]      fwd_sel_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_we, id_is_load, ex_jump_taken,
    input  stall, flush, issue, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_we, id_is_load, ex_jump_taken,
    output stall, flush, issue, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Per-operand priority encoder: youngest valid in-flight writer of rs wins; zero latency.
// load_hit flags that the winning writer is a load still in EX (entry 0), i.e. a load-use hazard.
module fwd_match
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int FWD_DEPTH  = 2,
  parameter int SEL_W      = sel_width(FWD_DEPTH)
) (
  input  logic [REG_ADDR_W-1:0]       rs,
  input  logic                        use_rs,
  input  trk_entry_t [FWD_DEPTH-1:0]  ent,
  output logic [SEL_W-1:0]            fwd_sel,
  output logic                        load_hit
);

  logic win_is_load;

  always_comb begin
    fwd_sel     = '0;
    win_is_load = 1'b0;
    if (use_rs && rs != '0) begin
      // Scan oldest to youngest so the lowest matching index is the last one written.
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (ent[k].valid && ent[k].rd == TRK_RD_W'(rs)) begin
          fwd_sel     = SEL_W'(k + 1);
          win_is_load = ent[k].is_load;
        end
      end
    end
    load_hit = win_is_load && (fwd_sel == SEL_W'(1));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and jump-flush controller between decode and EX; stall/flush/issue are same-cycle.
// Load-use stalls hold ID for one cycle; a taken jump squashes FLUSH_CYCLES ID slots, flush beats stall.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int FWD_DEPTH    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = sel_width(FWD_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [2:0] FRELOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t                state_q, state_d;
  logic [2:0]                 fcnt_q, fcnt_d;
  trk_entry_t [FWD_DEPTH-1:0] trk_q, trk_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;

  logic             jump_flush, flush, stall, issue;
  logic             hit_a, hit_b;
  logic [SEL_W-1:0] sel_a, sel_b;

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_a (
    .rs(bus.id_rs1), .use_rs(bus.id_uses_rs1), .ent(trk_q), .fwd_sel(sel_a), .load_hit(hit_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_b (
    .rs(bus.id_rs2), .use_rs(bus.id_uses_rs2), .ent(trk_q), .fwd_sel(sel_b), .load_hit(hit_b)
  );

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    jump_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_jump_taken) begin
          jump_flush = 1'b1;
          if (FRELOAD != 3'd0) begin
            state_d = FLUSH;
            fcnt_d  = FRELOAD;
          end
        end
      end
      FLUSH: begin
        jump_flush = 1'b1;
        if (bus.ex_jump_taken) begin
          fcnt_d = FRELOAD;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    // Outputs read as idle while reset is held, even with live decode inputs.
    flush = rst_n && jump_flush;
    stall = rst_n && bus.id_valid && (hit_a || hit_b) && !flush;
    issue = rst_n && bus.id_valid && !stall && !flush;

    trk_d = '0;
    if (issue && bus.id_reg_we && bus.id_rd != '0) begin
      trk_d[0] = '{valid: 1'b1, rd: TRK_RD_W'(bus.id_rd), is_load: bus.id_is_load};
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      trk_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.issue     = issue;
  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl (FWD_DEPTH=2, FLUSH_CYCLES=2, CNT_W=4).
// Expected per-cycle outputs are queued as each vector is driven and popped when sampled.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int SW = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic          stall;
    logic          flush;
    logic          issue;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
  } obs_t;

  typedef struct packed {
    logic          vld;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
    logic          jmp;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];

  pipe_hazard_ctrl_if #(.REG_ADDR_W(RW), .SEL_W(SW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W(RW), .FWD_DEPTH(2), .FLUSH_CYCLES(2), .CNT_W(CW), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(bit vld, int rs1, bit u1, int rs2, bit u2,
                               int rd, bit we, bit ld, bit jmp);
    stim_t s;
    s = '{vld: vld, rs1: RW'(rs1), u1: u1, rs2: RW'(rs2), u2: u2,
          rd: RW'(rd), we: we, ld: ld, jmp: jmp};
    return s;
  endfunction

  function automatic obs_t ob(bit stl, bit fl, bit is, int sa, int sb);
    obs_t o;
    o = '{stall: stl, flush: fl, issue: is, sa: SW'(sa), sb: SW'(sb)};
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{stall: bus.stall, flush: bus.flush, issue: bus.issue,
          sa: bus.fwd_sel_a, sb: bus.fwd_sel_b};
    return o;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid      = s.vld;
    bus.id_rs1        = s.rs1;
    bus.id_uses_rs1   = s.u1;
    bus.id_rs2        = s.rs2;
    bus.id_uses_rs2   = s.u2;
    bus.id_rd         = s.rd;
    bus.id_reg_we     = s.we;
    bus.id_is_load    = s.ld;
    bus.ex_jump_taken = s.jmp;
  endtask

  // Leaves the bench just after a falling edge with reset released and idle inputs.
  task automatic do_reset();
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    apply(st(1, 3, 1, 4, 1, 6, 1, 1, 1));
    rst_n = 1'b0;
    #2;
    got = observe();
    checks++;
    if (got !== ob(0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", got, ob(0, 0, 0, 0, 0));
    end
    checks++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[3];
    obs_t  e[3];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 2, 1, 5, 1, 0, 0),
          st(1, 5, 1, 1, 1, 6, 1, 0, 0),
          st(1, 5, 1, 0, 0, 8, 1, 0, 0)};
    e = '{ob(0, 0, 1, 0, 0), ob(0, 0, 1, 1, 0), ob(0, 0, 1, 2, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    stim_t s[3];
    obs_t  e[3];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 0, 0, 7, 1, 1, 0),
          st(1, 2, 1, 7, 1, 9, 1, 0, 0),
          st(1, 2, 1, 7, 1, 9, 1, 0, 0)};
    e = '{ob(0, 0, 1, 0, 0), ob(1, 0, 0, 0, 1), ob(0, 0, 1, 0, 2)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL load_use[%0d] got=%h exp=%h", i, got, ex);
      end
      if (i == 2) begin
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
          failures++;
          $display("FAIL load_use_stall_cnt got=%0d exp=1", bus.stall_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_x0_youngest();
    stim_t s[6];
    obs_t  e[6];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 0, 0, 0, 1, 0, 0),
          st(1, 0, 1, 0, 1, 4, 1, 0, 0),
          st(1, 1, 1, 0, 0, 3, 1, 0, 0),
          st(1, 2, 1, 3, 1, 3, 1, 0, 0),
          st(1, 3, 1, 0, 0, 0, 0, 0, 0),
          st(1, 3, 1, 3, 0, 0, 0, 0, 0)};
    e = '{ob(0, 0, 1, 0, 0), ob(0, 0, 1, 0, 0), ob(0, 0, 1, 0, 0),
          ob(0, 0, 1, 0, 1), ob(0, 0, 1, 1, 0), ob(0, 0, 1, 2, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL x0_youngest[%0d] got=%h exp=%h", i, got, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 0, 0, 5, 1, 0, 1),
          st(1, 1, 1, 0, 0, 6, 1, 0, 0),
          st(1, 5, 1, 6, 1, 0, 0, 0, 0),
          st(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{ob(0, 1, 0, 0, 0), ob(0, 1, 0, 0, 0), ob(0, 0, 1, 0, 0), ob(0, 0, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL flush[%0d] got=%h exp=%h", i, got, ex);
      end
      if (i == 2) begin
        checks++;
        if (bus.flush_cnt !== 4'd2) begin
          failures++;
          $display("FAIL flush_cnt got=%0d exp=2", bus.flush_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_extend();
    stim_t s[5];
    obs_t  e[5];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 0, 0, 0, 0, 5, 1, 0, 1),
          st(1, 0, 0, 0, 0, 6, 1, 0, 1),
          st(1, 0, 0, 0, 0, 9, 1, 0, 0),
          st(1, 5, 1, 6, 1, 0, 0, 0, 0),
          st(1, 9, 1, 0, 0, 0, 0, 0, 0)};
    e = '{ob(0, 1, 0, 0, 0), ob(0, 1, 0, 0, 0), ob(0, 1, 0, 0, 0),
          ob(0, 0, 1, 0, 0), ob(0, 0, 1, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL flush_extend[%0d] got=%h exp=%h", i, got, ex);
      end
      if (i == 3) begin
        checks++;
        if (bus.flush_cnt !== 4'd3) begin
          failures++;
          $display("FAIL flush_extend_cnt got=%0d exp=3", bus.flush_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_vs_stall();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 0, 0, 7, 1, 1, 0),
          st(1, 2, 1, 7, 1, 9, 1, 0, 1),
          st(1, 2, 1, 7, 1, 9, 1, 0, 0),
          st(1, 2, 1, 7, 1, 9, 1, 0, 0)};
    e = '{ob(0, 0, 1, 0, 0), ob(0, 1, 0, 0, 1), ob(0, 1, 0, 0, 2), ob(0, 0, 1, 0, 0)};
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = observe();
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        failures++;
        $display("FAIL flush_vs_stall[%0d] got=%h exp=%h", i, got, ex);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd2) begin
      failures++;
      $display("FAIL flush_vs_stall_cnt got=%0d/%0d exp=0/2", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_saturation();
    stim_t s[3];
    obs_t  e[3];
    obs_t  got, ex;
    do_reset();
    s = '{st(1, 1, 1, 0, 0, 7, 1, 1, 0),
          st(1, 2, 1, 7, 1, 0, 0, 0, 0),
          st(1, 2, 1, 7, 1, 0, 0, 0, 0)};
    e = '{ob(0, 0, 1, 0, 0), ob(1, 0, 0, 0, 1), ob(0, 0, 1, 0, 2)};
    for (int n = 0; n < 20; n++) begin
      foreach (s[i]) begin
        apply(s[i]);
        exp_q.push_back(e[i]);
        #2;
        got = observe();
        ex  = exp_q.pop_front();
        checks++;
        if (got !== ex) begin
          failures++;
          $display("FAIL saturation[%0d.%0d] got=%h exp=%h", n, i, got, ex);
        end
        @(negedge clk);
      end
      if (n == 4) begin
        checks++;
        if (bus.stall_cnt !== 4'd5) begin
          failures++;
          $display("FAIL stall_cnt_mid got=%0d exp=5", bus.stall_cnt);
        end
      end
    end
    checks++;
    if (bus.stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL stall_cnt_sat got=%0d exp=15", bus.stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got;
    do_reset();
    apply(st(1, 0, 0, 0, 0, 5, 1, 0, 1));
    #2;
    got = observe();
    checks++;
    if (got !== ob(0, 1, 0, 0, 0)) begin
      failures++;
      $display("FAIL mid_pre_jump got=%h exp=%h", got, ob(0, 1, 0, 0, 0));
    end
    @(negedge clk);
    apply(st(1, 1, 1, 0, 0, 5, 1, 0, 0));
    #2;
    checks++;
    if (bus.flush !== 1'b1 || bus.flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL mid_pre_flush got=%b/%0d exp=1/1", bus.flush, bus.flush_cnt);
    end
    rst_n = 1'b0;
    #1;
    got = observe();
    checks++;
    if (got !== ob(0, 0, 0, 0, 0) || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h cnt=%0d/%0d exp=%h cnt=0/0",
               got, bus.stall_cnt, bus.flush_cnt, ob(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    got = observe();
    checks++;
    if (got !== ob(0, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL mid_no_pending_flush got=%h exp=%h", got, ob(0, 0, 1, 0, 0));
    end
    @(negedge clk);
  endtask

  initial begin
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_youngest();
    test_flush();
    test_flush_extend();
    test_flush_vs_stall();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the pipelined CPU; successor to the fixed two-stage hazard unit.
- Sits between fetch/decode and the EX pipeline registers.
- Tracks in-flight destination registers across a configurable number of post-decode stages and selects the forwarding source per operand.
- Generates load-use stalls and multi-cycle branch/jump flushes, and keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register address width
FWD_DEPTH, 2, number of tracked post-decode stages (entry 0 = EX, entry FWD_DEPTH-1 = last stage before writeback commit); legal range 1..4
FLUSH_CYCLES, 2, ID/EX slots squashed after a taken jump; legal range 1..7
CNT_W, 16, width of performance counters
SEL_W, $clog2(FWD_DEPTH+1), forward-select width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1  in  REG_ADDR_W  source register 1
id_rs2  in  REG_ADDR_W  source register 2
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination register
id_reg_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load (mem_to_reg)
ex_jump_taken  in  1  jump/branch resolved taken in EX this cycle
stall  out  1  hold PC and ID, insert bubble into EX
flush  out  1  squash ID contents this cycle
issue  out  1  ID instruction enters EX at next edge
fwd_sel_a  out  SEL_W  rs1 source: 0 = register file, k = result of entry k-1
fwd_sel_b  out  SEL_W  rs2 source, same encoding
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - All tracking entries invalid; state RUN; flush counter 0.
  - stall_cnt = flush_cnt = 0.
  - Outputs: stall = 0, flush = 0, issue = 0, fwd_sel_a = fwd_sel_b = 0.
- Tracking shift register:
  - FWD_DEPTH entries, each {valid, rd, is_load}.
  - Every edge: entry k moves to entry k+1, and entry FWD_DEPTH-1 is discarded.
  - Entry 0 loads {1, id_rd, id_is_load} when issue = 1 and id_reg_we = 1 and id_rd != 0; otherwise it loads an invalid bubble.
- Forwarding (combinational from ID inputs and entries):
  - For each operand, take the lowest k with entry k valid and entry k rd == rs; then fwd_sel = k+1.
  - If there is no match, or the operand is unused, or rs == 0: fwd_sel = 0.
  - The youngest match always wins.
- Load-use:
  - Raised when id_valid and a used operand matches entry 0 with is_load = 1.
  - In that case stall = 1 and issue = 0, and a bubble enters entry 0.
  - The following cycle re-evaluates: the load is now in entry 1, so fwd_sel = 2 and there is no stall.
  - If FWD_DEPTH = 1, the stall persists until the load leaves tracking (fwd_sel = 0).
- FSM states RUN and FLUSH, with a 3-bit counter fcnt:
  - RUN: if ex_jump_taken, flush = 1 combinationally this cycle, then go to FLUSH with fcnt = FLUSH_CYCLES-1 (when FLUSH_CYCLES = 1, stay in RUN).
  - FLUSH: flush = 1 and fcnt decrements; return to RUN when fcnt reaches 0 at that edge.
  - A new ex_jump_taken while in FLUSH reloads fcnt to FLUSH_CYCLES-1.
- Priority and issue rules:
  - Flush overrides stall: when flush = 1, stall = 0 and issue = 0, and a bubble enters entry 0.
  - issue = id_valid & ~stall & ~flush.
  - id_valid = 0 gives stall = 0 and issue = 0.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush = 1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-flush or mid-stall returns immediately to the reset state; no pending flush survives.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - REG_ADDR_W default
  - typedef trk_entry_t {valid, rd, is_load}
  - enum ctrl_state_t {RUN, FLUSH}
  - localparam SEL_W function
- One sub-module, fwd_match: a priority encoder that takes rs, the use flag and the entry vector, and returns fwd_sel plus a load_hit flag at entry 0. It is instantiated twice, once per operand.

Test Plan:
- Reset with FWD_DEPTH = 2: assert rst_n = 0 mid-run -> all outputs 0 and counters 0 at the same cycle, without waiting for a clock edge.
- Back-to-back ALU ops: issue add x5 (we = 1), then sub with rs1 = x5 -> fwd_sel_a = 1 and stall = 0 for the sub; a third instruction reading x5 sees fwd_sel = 2.
- Load-use: issue lw x7, then add with rs2 = x7 -> one cycle with stall = 1 and issue = 0, next cycle fwd_sel_b = 2 and issue = 1; stall_cnt = 1.
- Register x0 and youngest-wins: write x0, then read x0 -> fwd_sel = 0; write x3 twice in consecutive instructions, then read x3 -> fwd_sel = 1.
- Flush with FLUSH_CYCLES = 2: pulse ex_jump_taken -> flush = 1 for exactly 2 cycles and no entries become valid; a second pulse in the 2nd flush cycle extends flush to 3 cycles total; flush_cnt = 3.
- Flush versus stall collision: a load-use condition coinciding with ex_jump_taken -> flush = 1, stall = 0, stall_cnt unchanged; counter saturation with CNT_W = 4: hold a stall for 20 cycles -> stall_cnt = 15.
